// File: rtl/ulpb_tx_arbiter_pkg.sv
// Shared definitions for the ULPB TX-side arbiter: bus widths, FSM encoding and
// a small modular-add helper used by the round-robin picker and pointer update.
package ulpb_tx_arbiter_pkg;

    localparam int unsigned ULPB_ADDR_WIDTH = 8;
    localparam int unsigned ULPB_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        ArbIdle  = 3'd0,
        ArbWreq  = 3'd1,
        ArbWack  = 3'd2,
        ArbWrel  = 3'd3,
        ArbNext  = 3'd4,
        ArbRwait = 3'd5,
        ArbRack  = 3'd6,
        ArbRrel  = 3'd7
    } arb_state_e;

    // (base + off) mod n, valid while base < n and off < n.
    function automatic int unsigned rr_wrap_add(input int unsigned base,
                                                input int unsigned off,
                                                input int unsigned n);
        int unsigned sum;
        sum = base + off;
        return (sum >= n) ? (sum - n) : sum;
    endfunction

endpackage

// File: rtl/ulpb_rr_pick.sv
// Combinational round-robin picker with a priority class. When any requester
// also asserts priority, only prioritized requesters compete; the winner is the
// first candidate at or after the pointer, wrapping around.
module ulpb_rr_pick
    import ulpb_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CLI = 4,
    parameter int unsigned PTR_W   = $clog2(NUM_CLI)
) (
    input  logic [NUM_CLI-1:0] req_i,
    input  logic [NUM_CLI-1:0] prio_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_CLI-1:0] win_o
);

    logic [NUM_CLI-1:0] hi_req;
    logic [NUM_CLI-1:0] cand;
    logic [PTR_W-1:0]   idx;
    logic               found;

    assign hi_req = req_i & prio_i;
    assign cand   = (|hi_req) ? hi_req : req_i;

    // Scan candidates starting at the pointer; first hit wins.
    always_comb begin
        win_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_CLI; i++) begin
            idx = PTR_W'(rr_wrap_add(32'(ptr_i), i, NUM_CLI));
            if (!found && cand[idx]) begin
                win_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ulpb_tx_arbiter.sv
// Per-message arbiter sharing one ulpb_node32 TX/response port between
// NUM_CLI local clients. The winner owns the node until every word of its
// message is sent and the node's SUCC/FAIL response has been handed back.
module ulpb_tx_arbiter
    import ulpb_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CLI     = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ADDR_WIDTH  = ULPB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = ULPB_DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_CLI-1:0]            CLI_REQ,
    input  logic [NUM_CLI*ADDR_WIDTH-1:0] CLI_ADDR,
    input  logic [NUM_CLI*DATA_WIDTH-1:0] CLI_DATA,
    input  logic [NUM_CLI-1:0]            CLI_PEND,
    input  logic [NUM_CLI-1:0]            CLI_PRIO,
    output logic [NUM_CLI-1:0]            CLI_ACK,
    output logic [NUM_CLI-1:0]            CLI_SUCC,
    output logic [NUM_CLI-1:0]            CLI_FAIL,
    input  logic [NUM_CLI-1:0]            CLI_RESP_ACK,
    output logic [ADDR_WIDTH-1:0]         TX_ADDR,
    output logic [DATA_WIDTH-1:0]         TX_DATA,
    output logic                          TX_REQ,
    output logic                          TX_PEND,
    output logic                          PRIORITY,
    input  logic                          TX_ACK,
    input  logic                          TX_SUCC,
    input  logic                          TX_FAIL,
    output logic                          TX_RESP_ACK,
    output logic [NUM_CLI-1:0]            GRANT,
    output logic                          BUSY
);

    localparam int unsigned IdxW = $clog2(NUM_CLI);

    // Node-side synchronizers
    logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
    logic [SYNC_STAGES-1:0] succ_sync_q, succ_sync_d;
    logic [SYNC_STAGES-1:0] fail_sync_q, fail_sync_d;
    logic                   tx_ack_s, tx_succ_s, tx_fail_s;

    // Arbitration state and registered outputs
    arb_state_e             state_q, state_d;
    logic [IdxW-1:0]        ptr_q, ptr_d;
    logic [IdxW-1:0]        gidx_q, gidx_d;
    logic [NUM_CLI-1:0]     grant_q, grant_d;
    logic                   busy_q, busy_d;
    logic                   tx_req_q, tx_req_d;
    logic                   tx_resp_ack_q, tx_resp_ack_d;
    logic [ADDR_WIDTH-1:0]  tx_addr_q, tx_addr_d;
    logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
    logic                   tx_pend_q, tx_pend_d;
    logic                   prio_q, prio_d;
    logic [NUM_CLI-1:0]     cli_ack_q, cli_ack_d;
    logic [NUM_CLI-1:0]     cli_succ_q, cli_succ_d;
    logic [NUM_CLI-1:0]     cli_fail_q, cli_fail_d;

    // Picker result and client field selection
    logic [NUM_CLI-1:0]     win_oh;
    logic [IdxW-1:0]        win_idx;
    logic [IdxW-1:0]        sel_idx;
    logic [ADDR_WIDTH-1:0]  cli_addr_a [NUM_CLI];
    logic [DATA_WIDTH-1:0]  cli_data_a [NUM_CLI];

    ulpb_rr_pick #(
        .NUM_CLI (NUM_CLI),
        .PTR_W   (IdxW)
    ) u_rr_pick (
        .req_i  (CLI_REQ),
        .prio_i (CLI_PRIO),
        .ptr_i  (ptr_q),
        .win_o  (win_oh)
    );

    // Shift each node input one stage deeper per cycle.
    always_comb begin
        ack_sync_d  = SYNC_STAGES'({ack_sync_q, TX_ACK});
        succ_sync_d = SYNC_STAGES'({succ_sync_q, TX_SUCC});
        fail_sync_d = SYNC_STAGES'({fail_sync_q, TX_FAIL});
    end

    assign tx_ack_s  = ack_sync_q[SYNC_STAGES-1];
    assign tx_succ_s = succ_sync_q[SYNC_STAGES-1];
    assign tx_fail_s = fail_sync_q[SYNC_STAGES-1];

    // Unpack client buses and encode the picker's one-hot winner.
    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < NUM_CLI; i++) begin
            cli_addr_a[i] = CLI_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
            cli_data_a[i] = CLI_DATA[i*DATA_WIDTH +: DATA_WIDTH];
            if (win_oh[i]) begin
                win_idx = IdxW'(i);
            end
        end
    end

    // Fields are latched from the winner at grant and from the owner in NEXT.
    assign sel_idx = (state_q == ArbIdle) ? win_idx : gidx_q;

    // Next-state and output decisions for the message-level handshake FSM.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        gidx_d        = gidx_q;
        grant_d       = grant_q;
        busy_d        = busy_q;
        tx_req_d      = tx_req_q;
        tx_resp_ack_d = tx_resp_ack_q;
        tx_addr_d     = tx_addr_q;
        tx_data_d     = tx_data_q;
        tx_pend_d     = tx_pend_q;
        prio_d        = prio_q;
        cli_ack_d     = cli_ack_q;
        cli_succ_d    = cli_succ_q;
        cli_fail_d    = cli_fail_q;

        case (state_q)
            ArbIdle: begin
                if (|win_oh) begin
                    gidx_d    = win_idx;
                    grant_d   = win_oh;
                    busy_d    = 1'b1;
                    tx_req_d  = 1'b1;
                    tx_addr_d = cli_addr_a[sel_idx];
                    tx_data_d = cli_data_a[sel_idx];
                    tx_pend_d = CLI_PEND[sel_idx];
                    prio_d    = CLI_PRIO[sel_idx];
                    state_d   = ArbWreq;
                end
            end
            ArbWreq: begin
                // A client dropping REQ here is ignored; the word still goes out.
                if (tx_ack_s) begin
                    cli_ack_d[gidx_q] = 1'b1;
                    state_d           = ArbWack;
                end
            end
            ArbWack: begin
                if (!CLI_REQ[gidx_q]) begin
                    tx_req_d = 1'b0;
                    state_d  = ArbWrel;
                end
            end
            ArbWrel: begin
                if (!tx_ack_s) begin
                    cli_ack_d[gidx_q] = 1'b0;
                    state_d           = tx_pend_q ? ArbNext : ArbRwait;
                end
            end
            ArbNext: begin
                // Lock held; PRIORITY keeps the value latched at grant.
                if (CLI_REQ[gidx_q]) begin
                    tx_req_d  = 1'b1;
                    tx_addr_d = cli_addr_a[sel_idx];
                    tx_data_d = cli_data_a[sel_idx];
                    tx_pend_d = CLI_PEND[sel_idx];
                    state_d   = ArbWreq;
                end
            end
            ArbRwait: begin
                if (tx_succ_s) begin
                    cli_succ_d[gidx_q] = 1'b1;
                    state_d            = ArbRack;
                end else if (tx_fail_s) begin
                    cli_fail_d[gidx_q] = 1'b1;
                    state_d            = ArbRack;
                end
            end
            ArbRack: begin
                if (CLI_RESP_ACK[gidx_q]) begin
                    tx_resp_ack_d = 1'b1;
                    state_d       = ArbRrel;
                end
            end
            ArbRrel: begin
                if (!tx_succ_s && !tx_fail_s) begin
                    cli_succ_d = '0;
                    cli_fail_d = '0;
                end
                // Release only once the client has seen its response drop.
                if (!cli_succ_d[gidx_q] && !cli_fail_d[gidx_q] && !CLI_RESP_ACK[gidx_q]) begin
                    tx_resp_ack_d = 1'b0;
                    ptr_d         = IdxW'(rr_wrap_add(32'(gidx_q), 1, NUM_CLI));
                    grant_d       = '0;
                    busy_d        = 1'b0;
                    state_d       = ArbIdle;
                end
            end
            default: begin
                state_d = ArbIdle;
            end
        endcase
    end

    // State, synchronizer and output registers; reset clears everything.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ack_sync_q    <= '0;
            succ_sync_q   <= '0;
            fail_sync_q   <= '0;
            state_q       <= ArbIdle;
            ptr_q         <= '0;
            gidx_q        <= '0;
            grant_q       <= '0;
            busy_q        <= 1'b0;
            tx_req_q      <= 1'b0;
            tx_resp_ack_q <= 1'b0;
            tx_addr_q     <= '0;
            tx_data_q     <= '0;
            tx_pend_q     <= 1'b0;
            prio_q        <= 1'b0;
            cli_ack_q     <= '0;
            cli_succ_q    <= '0;
            cli_fail_q    <= '0;
        end else begin
            ack_sync_q    <= ack_sync_d;
            succ_sync_q   <= succ_sync_d;
            fail_sync_q   <= fail_sync_d;
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            gidx_q        <= gidx_d;
            grant_q       <= grant_d;
            busy_q        <= busy_d;
            tx_req_q      <= tx_req_d;
            tx_resp_ack_q <= tx_resp_ack_d;
            tx_addr_q     <= tx_addr_d;
            tx_data_q     <= tx_data_d;
            tx_pend_q     <= tx_pend_d;
            prio_q        <= prio_d;
            cli_ack_q     <= cli_ack_d;
            cli_succ_q    <= cli_succ_d;
            cli_fail_q    <= cli_fail_d;
        end
    end

    assign CLI_ACK     = cli_ack_q;
    assign CLI_SUCC    = cli_succ_q;
    assign CLI_FAIL    = cli_fail_q;
    assign TX_ADDR     = tx_addr_q;
    assign TX_DATA     = tx_data_q;
    assign TX_REQ      = tx_req_q;
    assign TX_PEND     = tx_pend_q;
    assign PRIORITY    = prio_q;
    assign TX_RESP_ACK = tx_resp_ack_q;
    assign GRANT       = grant_q;
    assign BUSY        = busy_q;

endmodule

// File: tb/tb_ulpb_tx_arbiter.sv
// Scoreboard bench for ulpb_tx_arbiter: expected node-side words are queued as
// clients are launched and popped by a behavioural node when TX_REQ rises.
module tb_ulpb_tx_arbiter;

    localparam int NC = 4;
    localparam int SS = 2;
    localparam int AW = 8;
    localparam int DW = 32;

    localparam int PR_ACK   = 0;
    localparam int PR_RESP  = 1;
    localparam int PR_GRANT = 2;

    typedef struct {
        int          cli;
        logic [7:0]  addr;
        logic [31:0] data;
        bit          pend;
        bit          prio;
    } word_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic          cli_req      [NC];
    logic          cli_pend     [NC];
    logic          cli_prio     [NC];
    logic          cli_resp_ack [NC];
    logic [AW-1:0] cli_addr     [NC];
    logic [DW-1:0] cli_data     [NC];

    logic [NC-1:0]    req_v, pend_v, prio_v, resp_ack_v;
    logic [NC*AW-1:0] addr_v;
    logic [NC*DW-1:0] data_v;

    logic [NC-1:0] CLI_ACK, CLI_SUCC, CLI_FAIL, GRANT;
    logic [AW-1:0] TX_ADDR;
    logic [DW-1:0] TX_DATA;
    logic          TX_REQ, TX_PEND, PRIORITY, TX_RESP_ACK, BUSY;
    logic          tx_ack, tx_succ, tx_fail;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    word_t exp_q [$];
    bit    resp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < NC; i++) begin
            req_v[i]             = cli_req[i];
            pend_v[i]            = cli_pend[i];
            prio_v[i]            = cli_prio[i];
            resp_ack_v[i]        = cli_resp_ack[i];
            addr_v[i*AW +: AW]   = cli_addr[i];
            data_v[i*DW +: DW]   = cli_data[i];
        end
    end

    ulpb_tx_arbiter #(
        .NUM_CLI     (NC),
        .SYNC_STAGES (SS),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .CLI_REQ      (req_v),
        .CLI_ADDR     (addr_v),
        .CLI_DATA     (data_v),
        .CLI_PEND     (pend_v),
        .CLI_PRIO     (prio_v),
        .CLI_ACK      (CLI_ACK),
        .CLI_SUCC     (CLI_SUCC),
        .CLI_FAIL     (CLI_FAIL),
        .CLI_RESP_ACK (resp_ack_v),
        .TX_ADDR      (TX_ADDR),
        .TX_DATA      (TX_DATA),
        .TX_REQ       (TX_REQ),
        .TX_PEND      (TX_PEND),
        .PRIORITY     (PRIORITY),
        .TX_ACK       (tx_ack),
        .TX_SUCC      (tx_succ),
        .TX_FAIL      (tx_fail),
        .TX_RESP_ACK  (TX_RESP_ACK),
        .GRANT        (GRANT),
        .BUSY         (BUSY)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic probe(input int which, input int c);
        case (which)
            PR_ACK:  return CLI_ACK[c];
            PR_RESP: return CLI_SUCC[c] | CLI_FAIL[c];
            default: return GRANT[c];
        endcase
    endfunction

    // Bounded wait on a client-side DUT output; an expired bound shows as a failed check.
    task automatic wait_for(input string tag, input int which, input int c, input logic val);
        int n;
        n = 0;
        while (probe(which, c) !== val && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(probe(which, c)), 64'(val));
    endtask

    task automatic push_exp(input int c, input logic [7:0] a, input logic [31:0] d,
                            input bit pend, input bit prio);
        word_t w;
        w.cli = c; w.addr = a; w.data = d; w.pend = pend; w.prio = prio;
        exp_q.push_back(w);
    endtask

    // One client message: 4-phase word handshakes, then the response handshake.
    task automatic client_msg(input int c, input int nw, input logic [7:0] a,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input bit prio, input bit fail,
                              input int stall);
        logic [31:0] dw;
        for (int w = 0; w < nw; w++) begin
            dw = (w == 0) ? d0 : ((w == 1) ? d1 : d2);
            cli_addr[c] = a;
            cli_data[c] = dw;
            cli_pend[c] = (w < nw - 1);
            cli_prio[c] = prio;
            cli_req[c]  = 1'b1;
            wait_for("cli_ack_rise", PR_ACK, c, 1'b1);
            cli_req[c]  = 1'b0;
            cli_pend[c] = ~cli_pend[c];  // late PEND change must not matter
            wait_for("cli_ack_fall", PR_ACK, c, 1'b0);
            if (w < nw - 1) repeat (stall) @(negedge clk);
        end
        wait_for("cli_resp_rise", PR_RESP, c, 1'b1);
        chk("cli_succ_vec", 64'(CLI_SUCC), fail ? 64'(0) : 64'(1 << c));
        chk("cli_fail_vec", 64'(CLI_FAIL), fail ? 64'(1 << c) : 64'(0));
        repeat (3) @(negedge clk);
        chk("tx_resp_ack_early", 64'(TX_RESP_ACK), 64'(0));
        cli_resp_ack[c] = 1'b1;
        wait_for("cli_resp_fall", PR_RESP, c, 1'b0);
        cli_resp_ack[c] = 1'b0;
        wait_for("grant_release", PR_GRANT, c, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, 64'({CLI_ACK, CLI_SUCC, CLI_FAIL, GRANT, TX_REQ, TX_PEND,
                               PRIORITY, TX_RESP_ACK, BUSY}), 64'(0));
        chk({tag, "_addr"}, 64'(TX_ADDR), 64'(0));
        chk({tag, "_data"}, 64'(TX_DATA), 64'(0));
    endtask

    // Behavioural node: acks words, compares them with the scoreboard, returns a response.
    int    nst;
    int    dly;
    int    ack_cyc;
    bit    lat_done;
    bit    last_pend;
    bit    rfail;
    word_t nw_w;

    initial begin
        tx_ack = 1'b0; tx_succ = 1'b0; tx_fail = 1'b0;
        nst = 0; dly = 0; ack_cyc = 0; lat_done = 1'b0; last_pend = 1'b0; rfail = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                nst = 0; tx_ack = 1'b0; tx_succ = 1'b0; tx_fail = 1'b0;
            end else begin
                case (nst)
                    0: if (TX_REQ) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_word", 64'(1), 64'(0));
                            last_pend = TX_PEND;
                        end else begin
                            nw_w = exp_q.pop_front();
                            chk("grant", 64'(GRANT), 64'(1 << nw_w.cli));
                            chk("tx_addr", 64'(TX_ADDR), 64'(nw_w.addr));
                            chk("tx_data", 64'(TX_DATA), 64'(nw_w.data));
                            chk("tx_pend", 64'(TX_PEND), 64'(nw_w.pend));
                            chk("priority", 64'(PRIORITY), 64'(nw_w.prio));
                            chk("busy", 64'(BUSY), 64'(1));
                            last_pend = nw_w.pend;
                        end
                        tx_ack   = 1'b1;
                        ack_cyc  = cyc;
                        lat_done = 1'b0;
                        nst      = 1;
                    end
                    1: begin
                        if (!lat_done && (|CLI_ACK)) begin
                            chk("cli_ack_latency", 64'(cyc - ack_cyc), 64'(SS + 1));
                            lat_done = 1'b1;
                        end
                        if (!TX_REQ) begin
                            tx_ack = 1'b0;
                            dly    = 0;
                            nst    = last_pend ? 0 : 2;
                        end
                    end
                    2: begin
                        dly++;
                        if (dly == 4) begin
                            chk("tx_req_quiet", 64'(TX_REQ), 64'(0));
                            rfail   = (resp_q.size() != 0) ? resp_q.pop_front() : 1'b0;
                            tx_succ = !rfail;
                            tx_fail = rfail;
                            nst     = 3;
                        end
                    end
                    3: if (TX_RESP_ACK) begin
                        tx_succ = 1'b0;
                        tx_fail = 1'b0;
                        nst     = 4;
                    end
                    default: if (!TX_RESP_ACK) nst = 0;
                endcase
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected finish", cyc);
        $fatal(1, "watchdog");
    end

    bit lock_seen;
    int lock_n;

    initial begin
        for (int i = 0; i < NC; i++) begin
            cli_req[i] = 1'b0; cli_pend[i] = 1'b0; cli_prio[i] = 1'b0;
            cli_resp_ack[i] = 1'b0; cli_addr[i] = '0; cli_data[i] = '0;
        end
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        resetn = 1'b1;
        @(negedge clk);

        // Priority at pointer 0: client 3 (prio) beats client 0 although 0 is at the pointer.
        push_exp(3, 8'h33, 32'h3000_0001, 1'b0, 1'b1);
        push_exp(0, 8'h0a, 32'h0a0a_0a0a, 1'b0, 1'b0);
        resp_q.push_back(1'b0); resp_q.push_back(1'b0);
        fork
            client_msg(3, 1, 8'h33, 32'h3000_0001, '0, '0, 1'b1, 1'b0, 0);
            client_msg(0, 1, 8'h0a, 32'h0a0a_0a0a, '0, '0, 1'b0, 1'b0, 0);
        join

        // Single word from client 1 (pointer -> 2).
        push_exp(1, 8'hcd, 32'hdead_beef, 1'b0, 1'b0);
        resp_q.push_back(1'b0);
        client_msg(1, 1, 8'hcd, 32'hdead_beef, '0, '0, 1'b0, 1'b0, 0);
        @(negedge clk);
        chk("idle_grant", 64'(GRANT), 64'(0));
        chk("idle_busy", 64'(BUSY), 64'(0));

        // Pointer now 2: client 2 wins over client 0.
        push_exp(2, 8'h02, 32'h0000_0002, 1'b0, 1'b0);
        push_exp(0, 8'h01, 32'h0000_0001, 1'b0, 1'b0);
        resp_q.push_back(1'b0); resp_q.push_back(1'b0);
        fork
            client_msg(0, 1, 8'h01, 32'h0000_0001, '0, '0, 1'b0, 1'b0, 0);
            client_msg(2, 1, 8'h02, 32'h0000_0002, '0, '0, 1'b0, 1'b0, 0);
        join

        // Failure routed to client 1 only.
        push_exp(1, 8'h41, 32'hf00d_cafe, 1'b0, 1'b0);
        resp_q.push_back(1'b1);
        client_msg(1, 1, 8'h41, 32'hf00d_cafe, '0, '0, 1'b0, 1'b1, 0);

        // Multi-word lock: client 2 stalls in NEXT while client 0 waits.
        push_exp(2, 8'h22, 32'h1111_1111, 1'b1, 1'b0);
        push_exp(2, 8'h22, 32'h2222_2222, 1'b1, 1'b0);
        push_exp(2, 8'h22, 32'h3333_3333, 1'b0, 1'b0);
        push_exp(0, 8'h05, 32'h0000_0005, 1'b0, 1'b0);
        resp_q.push_back(1'b0); resp_q.push_back(1'b0);
        fork
            client_msg(2, 3, 8'h22, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
                       1'b0, 1'b0, 50);
            begin
                repeat (5) @(negedge clk);
                client_msg(0, 1, 8'h05, 32'h0000_0005, '0, '0, 1'b0, 1'b0, 0);
            end
            begin
                wait_for("lock_grant", PR_GRANT, 2, 1'b1);
                lock_seen = 1'b0;
                lock_n    = 0;
                while (GRANT[2] && lock_n < 5000) begin
                    if (CLI_ACK[0] || GRANT[0]) lock_seen = 1'b1;
                    @(negedge clk);
                    lock_n++;
                end
                chk("lock_held", 64'(lock_seen), 64'(0));
            end
        join

        // Client 3 alone (pointer -> 0), then round-robin 0, 2, 3.
        push_exp(3, 8'h3c, 32'h0000_0003, 1'b0, 1'b0);
        resp_q.push_back(1'b0);
        client_msg(3, 1, 8'h3c, 32'h0000_0003, '0, '0, 1'b0, 1'b0, 0);
        push_exp(0, 8'h80, 32'h8000_0000, 1'b0, 1'b0);
        push_exp(2, 8'h82, 32'h8000_0002, 1'b0, 1'b0);
        push_exp(3, 8'h83, 32'h8000_0003, 1'b0, 1'b0);
        repeat (3) resp_q.push_back(1'b0);
        fork
            client_msg(0, 1, 8'h80, 32'h8000_0000, '0, '0, 1'b0, 1'b0, 0);
            client_msg(2, 1, 8'h82, 32'h8000_0002, '0, '0, 1'b0, 1'b0, 0);
            client_msg(3, 1, 8'h83, 32'h8000_0003, '0, '0, 1'b0, 1'b0, 0);
        join

        // Client 2 alone leaves the pointer at 3.
        push_exp(2, 8'h2a, 32'h2a2a_2a2a, 1'b0, 1'b0);
        resp_q.push_back(1'b0);
        client_msg(2, 1, 8'h2a, 32'h2a2a_2a2a, '0, '0, 1'b0, 1'b0, 0);

        // Reset while client 2 sits in WACK; afterwards pointer 0 favours client 1 over 3.
        push_exp(2, 8'h2e, 32'h2e2e_2e2e, 1'b0, 1'b0);
        cli_addr[2] = 8'h2e; cli_data[2] = 32'h2e2e_2e2e; cli_pend[2] = 1'b0;
        cli_prio[2] = 1'b0;  cli_req[2] = 1'b1;
        wait_for("rst_wack", PR_ACK, 2, 1'b1);
        resetn = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        for (int i = 0; i < NC; i++) begin
            cli_req[i] = 1'b0; cli_resp_ack[i] = 1'b0;
        end
        exp_q.delete();
        resp_q.delete();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        push_exp(1, 8'h91, 32'h9000_0001, 1'b0, 1'b0);
        push_exp(3, 8'h93, 32'h9000_0003, 1'b0, 1'b0);
        resp_q.push_back(1'b0); resp_q.push_back(1'b0);
        fork
            client_msg(1, 1, 8'h91, 32'h9000_0001, '0, '0, 1'b0, 1'b0, 0);
            client_msg(3, 1, 8'h93, 32'h9000_0003, '0, '0, 1'b0, 1'b0, 0);
        join
        repeat (5) @(negedge clk);
        chk("exp_queue_drained", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
